trace_mon: RTL and testbench
============================

TRACE_MON -- requirements
Module: trace_mon

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath width of PC and write-data fields.
REQ-002 SHALL provide parameter DEPTH, default 16, trace-buffer entries; power of two, >=2.
REQ-003 SHALL provide parameter TIMEOUT, default 256, consecutive idle cycles before timeout.
REQ-004 SHALL have ports, in order:
- clk  in  1  clock; rising edge.
- rst  in  1  reset; asynchronous, active-low.
- ret_valid  in  1  one instruction retires this cycle.
- ret_pc  in  XLEN  PC of the retiring instruction.
- ret_ir  in  32  encoding of the retiring instruction.
- ret_we  in  1  retiring instruction writes a GPR.
- ret_rd  in  5  destination register index.
- ret_wdata  in  XLEN  destination write data.
- state  out  2  00 RUN, 01 HALT, 10 TIMEOUT.
- retire_cnt  out  32  retired-instruction count.
- cycle_cnt  out  32  cycles spent in RUN.
- dump_valid  out  1  dump entry present.
- dump_ready  in  1  consumer accepts the dump entry.
- dump_pc / dump_ir / dump_we / dump_rd / dump_wdata  out  XLEN/32/1/5/XLEN  fields of the current dump entry.
- dump_done  out  1  frozen state and all entries dumped.
- shadow_idx  in  5  shadow read index; present only with the macro.
- shadow_data  out  XLEN  shadow register value; present only with the macro.

Function
REQ-005 SHALL, in RUN with ret_valid=1, write {pc, ir, we, rd, wdata} at wptr, advance wptr mod DEPTH, set count=min(count+1, DEPTH) and increment retire_cnt (wraps at 2^32).
REQ-006 SHALL overwrite the oldest entry when count=DEPTH, so the buffer always holds the last DEPTH retirements.
REQ-007 SHALL increment cycle_cnt on every RUN cycle, saturating at 0xFFFFFFFF, and freeze it outside RUN.
REQ-008 SHALL transition RUN->HALT on the edge after a retirement whose ir is 0x00000073 (ecall), 0x00100073 (ebreak) or 0x0000006F (jal x0,0); that retirement SHALL be recorded.
REQ-009 SHALL maintain an idle counter, cleared by ret_valid, and SHALL transition RUN->TIMEOUT on the edge ending the TIMEOUT-th consecutive cycle with ret_valid=0.
REQ-010 SHALL make HALT and TIMEOUT terminal until reset; ret_valid SHALL then be ignored and no counter except dump state SHALL change.
REQ-011 SHALL, on entering HALT or TIMEOUT, set rptr=(wptr-count) mod DEPTH and remaining=count.
REQ-012 SHALL hold dump_valid=1 when frozen and remaining>0, with dump_* driven combinationally from entry rptr.
REQ-013 SHALL, when dump_valid&dump_ready, advance rptr mod DEPTH and decrement remaining; dump_* SHALL remain stable while dump_valid=1 and dump_ready=0.
REQ-014 SHALL assert dump_done when frozen and remaining=0, including TIMEOUT with zero retirements (asserted in the first cycle of TIMEOUT).
REQ-015 SHALL emit dump entries oldest first; the first dump_valid SHALL occur in the first cycle of the frozen state.

Reset
REQ-016 SHALL, while rst=0, force state=RUN, wptr=rptr=count=remaining=idle=0, retire_cnt=cycle_cnt=0, dump_valid=0, dump_done=0 and dump_* outputs to 0, independent of clk.
REQ-017 SHALL abandon any dump in progress on reset; buffer contents need not be cleared.

Configuration
REQ-018 SHALL, with TRACE_MON_SHADOW_REGS_EN defined, keep a 32xXLEN shadow register file updated in RUN on ret_valid&ret_we with ret_rd!=0, cleared by reset; shadow_data=shadow[shadow_idx] combinationally, and index 0 SHALL read 0.
REQ-019 SHALL, without TRACE_MON_SHADOW_REGS_EN, omit the shadow_idx and shadow_data ports and the shadow storage.

Verification
REQ-020 SHALL check: retirements of pc 0,4,8, then ir=0x00000073 at pc 12 -> state=01, dump yields pcs 0,4,8,12, then dump_done=1; retire_cnt=4.
REQ-021 SHALL check: DEPTH=16, 20 retirements at pcs 0..76 step 4, then ebreak at pc 80 -> dump yields pcs 20..80 (16 entries), oldest first.
REQ-022 SHALL check: with TIMEOUT=256 and no retirement after reset release -> state=10 after 256 cycles, dump_done=1, dump_valid=0.
REQ-023 SHALL check: dump_ready toggling 1,0,0,1 -> dump_* held stable during stalls, with no entry lost or duplicated.
REQ-024 SHALL check: rst pulled low mid-dump -> all outputs 0 and state=RUN immediately, without waiting for a clk edge.
REQ-025 SHALL check, with the macro defined: a write of 0xDEADBEEF to x5 and a write of 0x1 to x0 -> shadow[5]=0xDEADBEEF, shadow[0]=0.

Source files
------------

// File: rtl/trace_mon.sv
// trace_mon: retirement trace buffer with halt/timeout freeze and dump port.
// Optional shadow GPR file built when TRACE_MON_SHADOW_REGS_EN is defined.
module trace_mon #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ret_valid,
  input  logic [XLEN-1:0] ret_pc,
  input  logic [31:0]     ret_ir,
  input  logic            ret_we,
  input  logic [4:0]      ret_rd,
  input  logic [XLEN-1:0] ret_wdata,
  output logic [1:0]      state,
  output logic [31:0]     retire_cnt,
  output logic [31:0]     cycle_cnt,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [XLEN-1:0] dump_pc,
  output logic [31:0]     dump_ir,
  output logic            dump_we,
  output logic [4:0]      dump_rd,
  output logic [XLEN-1:0] dump_wdata,
  output logic            dump_done
`ifdef TRACE_MON_SHADOW_REGS_EN
  ,
  input  logic [4:0]      shadow_idx,
  output logic [XLEN-1:0] shadow_data
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_RUN  = 2'b00;
  localparam logic [1:0] ST_HALT = 2'b01;
  localparam logic [1:0] ST_TMO  = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [31:0]   retire_q, retire_d;
  logic [31:0]   cycle_q, cycle_d;

  logic run;
  logic wr_en;
  logic halt_ir;

  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [31:0]     ir_mem [DEPTH];
  logic            we_mem [DEPTH];
  logic [4:0]      rd_mem [DEPTH];
  logic [XLEN-1:0] wd_mem [DEPTH];

  assign run     = (state_q == ST_RUN);
  assign wr_en   = run && ret_valid;
  assign halt_ir = (ret_ir == 32'h0000_0073) ||
                   (ret_ir == 32'h0010_0073) ||
                   (ret_ir == 32'h0000_006F);

  assign dump_valid = !run && (rem_q != '0);
  assign dump_done  = !run && (rem_q == '0);

  assign state      = state_q;
  assign retire_cnt = retire_q;
  assign cycle_cnt  = cycle_q;

  assign dump_pc    = dump_valid ? pc_mem[rptr_q] : '0;
  assign dump_ir    = dump_valid ? ir_mem[rptr_q] : '0;
  assign dump_we    = dump_valid ? we_mem[rptr_q] : 1'b0;
  assign dump_rd    = dump_valid ? rd_mem[rptr_q] : '0;
  assign dump_wdata = dump_valid ? wd_mem[rptr_q] : '0;

  // Next-state: record/count in RUN, freeze on halt or idle, then drain.
  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    rem_d    = rem_q;
    idle_d   = idle_q;
    retire_d = retire_q;
    cycle_d  = cycle_q;
    if (run) begin
      if (cycle_q != 32'hFFFF_FFFF) cycle_d = cycle_q + 32'd1;
      if (ret_valid) begin
        wptr_d   = wptr_q + AW'(1);
        retire_d = retire_q + 32'd1;
        idle_d   = '0;
        if (count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
        if (halt_ir) state_d = ST_HALT;
      end else if (idle_q == IW'(TIMEOUT - 1)) begin
        state_d = ST_TMO;
      end else begin
        idle_d = idle_q + IW'(1);
      end
      if (state_d != ST_RUN) begin
        rptr_d = wptr_d - count_d[AW-1:0];
        rem_d  = count_d;
      end
    end else if (dump_valid && dump_ready) begin
      rptr_d = rptr_q + AW'(1);
      rem_d  = rem_q - CW'(1);
    end
  end

  // Control and counter registers with async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rem_q    <= '0;
      idle_q   <= '0;
      retire_q <= '0;
      cycle_q  <= '0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      idle_q   <= idle_d;
      retire_q <= retire_d;
      cycle_q  <= cycle_d;
    end
  end

  // Trace storage; contents survive reset since pointers gate reads.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wptr_q] <= ret_pc;
      ir_mem[wptr_q] <= ret_ir;
      we_mem[wptr_q] <= ret_we;
      rd_mem[wptr_q] <= ret_rd;
      wd_mem[wptr_q] <= ret_wdata;
    end
  end

`ifdef TRACE_MON_SHADOW_REGS_EN
  logic [XLEN-1:0] shadow_q [32];

  // Shadow GPR file tracks retired writes; x0 never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
    end else if (wr_en && ret_we && (ret_rd != 5'd0)) begin
      shadow_q[ret_rd] <= ret_wdata;
    end
  end

  assign shadow_data = (shadow_idx == 5'd0) ? '0 : shadow_q[shadow_idx];
`else
  // No shadow register file in this build.
`endif

endmodule

// File: tb/tb_trace_mon.sv
// tb_trace_mon: directed + random checks of trace_mon against a queue model.
// Shadow register checks compile in with TRACE_MON_SHADOW_REGS_EN.
module tb_trace_mon;

  localparam int XLEN    = 32;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 256;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ret_valid = 1'b0;
  logic [31:0]     ret_pc = '0;
  logic [31:0]     ret_ir = '0;
  logic            ret_we = 1'b0;
  logic [4:0]      ret_rd = '0;
  logic [31:0]     ret_wdata = '0;
  logic [1:0]      state;
  logic [31:0]     retire_cnt;
  logic [31:0]     cycle_cnt;
  logic            dump_valid;
  logic            dump_ready = 1'b0;
  logic [31:0]     dump_pc;
  logic [31:0]     dump_ir;
  logic            dump_we;
  logic [4:0]      dump_rd;
  logic [31:0]     dump_wdata;
  logic            dump_done;
`ifdef TRACE_MON_SHADOW_REGS_EN
  logic [4:0]      shadow_idx = '0;
  logic [31:0]     shadow_data;
`endif

  trace_mon #(
    .XLEN(XLEN),
    .DEPTH(DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ret_valid(ret_valid),
    .ret_pc(ret_pc),
    .ret_ir(ret_ir),
    .ret_we(ret_we),
    .ret_rd(ret_rd),
    .ret_wdata(ret_wdata),
    .state(state),
    .retire_cnt(retire_cnt),
    .cycle_cnt(cycle_cnt),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_pc(dump_pc),
    .dump_ir(dump_ir),
    .dump_we(dump_we),
    .dump_rd(dump_rd),
    .dump_wdata(dump_wdata),
    .dump_done(dump_done)
`ifdef TRACE_MON_SHADOW_REGS_EN
    ,
    .shadow_idx(shadow_idx),
    .shadow_data(shadow_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } ent_t;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] JAL0   = 32'h0000_006F;

  ent_t   q[$];
  int     m_state;
  longint m_ret;
  longint m_cyc;
  int     m_idle;
  int     n_chk = 0;
  int     n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_state = 0;
    m_ret   = 0;
    m_cyc   = 0;
    m_idle  = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ret_valid = 1'b0;
    dump_ready = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_state"}, state, m_state);
    chk({tag, "_retire"}, retire_cnt, m_ret[31:0]);
    chk({tag, "_cycle"}, cycle_cnt, m_cyc[31:0]);
  endtask

  task automatic chk_zero(input string tag);
    chk_counters(tag);
    chk({tag, "_dvalid"}, dump_valid, 0);
    chk({tag, "_ddone"}, dump_done, 0);
    chk({tag, "_dpc"}, dump_pc, 0);
    chk({tag, "_dir"}, dump_ir, 0);
    chk({tag, "_dwe"}, dump_we, 0);
    chk({tag, "_drd"}, dump_rd, 0);
    chk({tag, "_dwd"}, dump_wdata, 0);
  endtask

  // One clock of retirement input, with the model advanced by the rules.
  task automatic cyc(input logic v, input logic [31:0] pc,
                     input logic [31:0] ir, input logic we,
                     input logic [4:0] rd, input logic [31:0] wd);
    ent_t e;
    ret_valid = v;
    ret_pc = pc;
    ret_ir = ir;
    ret_we = we;
    ret_rd = rd;
    ret_wdata = wd;
    @(posedge clk);
    if (m_state == 0) begin
      if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
      if (v) begin
        e.pc = pc; e.ir = ir; e.we = we; e.rd = rd; e.wdata = wd;
        q.push_back(e);
        if (q.size() > DEPTH) q.delete(0);
        m_ret++;
        m_idle = 0;
        if (ir == ECALL || ir == EBREAK || ir == JAL0) m_state = 1;
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) m_state = 2;
      end
    end
    #1;
    ret_valid = 1'b0;
    chk_counters("cyc");
    chk("cyc_dvalid", dump_valid, (m_state != 0) && (q.size() != 0));
    chk("cyc_ddone", dump_done, (m_state != 0) && (q.size() == 0));
  endtask

  // Drain up to max_ent entries; mode 0 ready, 1 pattern 1001, 2 random.
  task automatic drain(input int mode, input int max_ent);
    int taken = 0;
    logic r;
    for (int i = 0; i < 200; i++) begin
      if (max_ent >= 0 && taken == max_ent) return;
      chk("dr_valid", dump_valid, q.size() != 0);
      if (q.size() == 0) break;
      chk("dr_pc", dump_pc, q[0].pc);
      chk("dr_ir", dump_ir, q[0].ir);
      chk("dr_we", dump_we, q[0].we);
      chk("dr_rd", dump_rd, q[0].rd);
      chk("dr_wd", dump_wdata, q[0].wdata);
      case (mode)
        0: r = 1'b1;
        1: r = (i % 4 == 0) || (i % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      dump_ready = r;
      @(posedge clk);
      #1;
      if (r) begin
        q.delete(0);
        taken++;
      end
    end
    dump_ready = 1'b0;
    chk("dr_done", dump_done, 1);
    chk("dr_valid_end", dump_valid, 0);
    chk_counters("dr");
  endtask

  initial begin
    model_clear();
    #1 rst = 1'b0;
    #2 chk_zero("rst0");
    @(negedge clk);
    rst = 1'b1;

    // Three retirements then ecall; dump returns them in order.
    cyc(1, 32'd0, NOP, 1'b0, 5'd0, 32'd0);
    cyc(1, 32'd4, NOP, 1'b1, 5'd3, 32'h1234);
    cyc(1, 32'd8, NOP, 1'b0, 5'd0, 32'd0);
    cyc(1, 32'd12, ECALL, 1'b0, 5'd0, 32'd0);
    chk("a_state", state, 2'b01);
    chk("a_retire", retire_cnt, 4);
    cyc(1, 32'd100, NOP, 1'b1, 5'd1, 32'd9);
    drain(0, -1);

    // Wrap-around: 20 retirements plus ebreak keeps the newest 16.
    do_reset();
    for (int i = 0; i < 20; i++)
      cyc(1, 32'(i * 4), NOP, 1'b1, 5'(i), 32'(i * 3));
    cyc(1, 32'd80, EBREAK, 1'b0, 5'd0, 32'd0);
    chk("b_qsize", q.size(), DEPTH);
    chk("b_first_pc", dump_pc, 32'd20);
    drain(1, -1);

    // Random traffic ending in jal x0,0; partial drain then reset.
    do_reset();
    begin
      logic [31:0] pc = $urandom & 32'hFFFF_FFFC;
      for (int i = 0; i < 40; i++) begin
        cyc(1'($urandom_range(0, 3) != 0), pc, $urandom | 32'h8000_0000,
            1'($urandom_range(0, 1)), 5'($urandom), $urandom);
        pc += 32'd4;
      end
      cyc(1, pc, JAL0, 1'b0, 5'd0, 32'd0);
    end
    chk("c_state", state, 2'b01);
    drain(2, 5);
    #1 rst = 1'b0;
    model_clear();
    #1 chk_zero("rst_mid");
    @(negedge clk);
    rst = 1'b1;

    // No retirements: timeout after exactly TIMEOUT idle cycles.
    for (int i = 0; i < TIMEOUT; i++)
      cyc(0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t_state", state, 2'b10);
    chk("t_done", dump_done, 1);
    chk("t_valid", dump_valid, 0);
    chk("t_cycle", cycle_cnt, TIMEOUT);
    cyc(1, 32'd4, ECALL, 1'b1, 5'd2, 32'd1);

`ifdef TRACE_MON_SHADOW_REGS_EN
    do_reset();
    cyc(1, 32'd0, NOP, 1'b1, 5'd5, 32'hDEAD_BEEF);
    cyc(1, 32'd4, NOP, 1'b1, 5'd0, 32'h1);
    shadow_idx = 5'd5;
    #1 chk("sh_x5", shadow_data, 32'hDEAD_BEEF);
    shadow_idx = 5'd0;
    #1 chk("sh_x0", shadow_data, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
